// File: rtl/gate_bank_self_test_pkg.sv
// Shared constants for the gate-bank self test: gate bit positions,
// the expected truth table per (a,b) vector, and the sequencer states.
package gate_bank_self_test_pkg;

  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_NOT  = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XOR  = 5;
  localparam int GATE_XNOR = 6;

  localparam logic [6:0] EXP_V0 = 7'h5C;
  localparam logic [6:0] EXP_V1 = 7'h2E;
  localparam logic [6:0] EXP_V2 = 7'h2A;
  localparam logic [6:0] EXP_V3 = 7'h43;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [6:0] exp_for(input logic [1:0] idx);
    logic [6:0] e;
    case (idx)
      2'd0:    e = EXP_V0;
      2'd1:    e = EXP_V1;
      2'd2:    e = EXP_V2;
      default: e = EXP_V3;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/gate_bank_self_test_if.sv
// Control/status bundle between a test harness (master) and the sequencer (slave).
// start/abort are level inputs sampled on clk; done is a one-cycle pulse.
interface gate_bank_self_test_if;
  logic       start;
  logic       abort;
  logic [6:0] fault_inj;
  logic       busy;
  logic       done;
  logic       pass;
  logic [6:0] fail_mask;
  logic [3:0] fail_vec;
  logic [1:0] vec_idx;

  modport master (
    output start, abort, fault_inj,
    input  busy, done, pass, fail_mask, fail_vec, vec_idx
  );

  modport slave (
    input  start, abort, fault_inj,
    output busy, done, pass, fail_mask, fail_vec, vec_idx
  );
endinterface

// File: rtl/gate_bank_self_test_bank.sv
// Purely combinational 2-input, 7-output logic gate bank.
module logic_gate_bank
  import gate_bank_self_test_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  output logic [6:0] y_o
);

  always_comb begin
    y_o            = '0;
    y_o[GATE_AND]  = a_i & b_i;
    y_o[GATE_OR]   = a_i | b_i;
    y_o[GATE_NOT]  = ~a_i;
    y_o[GATE_NAND] = ~(a_i & b_i);
    y_o[GATE_NOR]  = ~(a_i | b_i);
    y_o[GATE_XOR]  = a_i ^ b_i;
    y_o[GATE_XNOR] = ~(a_i ^ b_i);
  end

endmodule

// File: rtl/gate_bank_self_test.sv
// Self-test sequencer: walks the gate bank through all four (a,b) vectors,
// compares against the expected table and accumulates sticky fail flags.
module gate_bank_self_test
  import gate_bank_self_test_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter bit          LOOP          = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  gate_bank_self_test_if.slave  ctl,
  output state_t                state_o
);

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] vec_q, vec_d;
  logic [6:0] mask_q, mask_d;
  logic [3:0] fvec_q, fvec_d;
  logic       pass_q, pass_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic [6:0] y;
  logic [6:0] mism;

  logic_gate_bank u_bank (
    .a_i (a_q),
    .b_i (b_q),
    .y_o (y)
  );

  assign mism = (y ^ ctl.fault_inj) ^ exp_for(vec_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    mask_d  = mask_q;
    fvec_d  = fvec_q;
    pass_d  = pass_q;
    a_d     = a_q;
    b_d     = b_q;
    // Abort outranks every state transition, including the DONE pulse's successor.
    if (state_q != ST_IDLE && ctl.abort) begin
      state_d = ST_IDLE;
      vec_d   = 2'd0;
      mask_d  = '0;
      fvec_d  = '0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ctl.start && !ctl.abort) begin
            state_d = ST_APPLY;
            vec_d   = 2'd0;
            mask_d  = '0;
            fvec_d  = '0;
            pass_d  = 1'b0;
          end
        end
        ST_APPLY: begin
          a_d     = vec_q[1];
          b_d     = vec_q[0];
          cnt_d   = SETTLE;
          state_d = (SETTLE == 4'd0) ? ST_CHECK : ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q <= 4'd1) begin
            cnt_d   = 4'd0;
            state_d = ST_CHECK;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ST_CHECK: begin
          mask_d        = mask_q | mism;
          fvec_d[vec_q] = fvec_q[vec_q] | (|mism);
          if (vec_q == 2'd3) begin
            state_d = ST_DONE;
            pass_d  = ~|(mask_q | mism);
          end else begin
            vec_d   = vec_q + 2'd1;
            state_d = ST_APPLY;
          end
        end
        ST_DONE: begin
          if (LOOP) begin
            state_d = ST_APPLY;
            vec_d   = 2'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      mask_q  <= '0;
      fvec_q  <= '0;
      pass_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      mask_q  <= mask_d;
      fvec_q  <= fvec_d;
      pass_q  <= pass_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign ctl.busy      = (state_q != ST_IDLE);
  assign ctl.done      = (state_q == ST_DONE);
  assign ctl.pass      = pass_q;
  assign ctl.fail_mask = mask_q;
  assign ctl.fail_vec  = fvec_q;
  assign ctl.vec_idx   = vec_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_gate_bank_self_test.sv
// Directed and randomized bench for the gate-bank self-test sequencer with
// three instances: settle 1 single-pass, settle 0 looping, settle 3 single-pass.
module tb_gate_bank_self_test;
  import gate_bank_self_test_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic       start_s  [3];
  logic       abort_s  [3];
  logic [6:0] fi_s     [3];
  logic       busy_o   [3];
  logic       done_o   [3];
  logic       pass_o   [3];
  logic [6:0] mask_o   [3];
  logic [3:0] fvec_o   [3];
  logic [1:0] vidx_o   [3];
  state_t     st_o     [3];

  gate_bank_self_test_if if0 ();
  gate_bank_self_test_if if1 ();
  gate_bank_self_test_if if2 ();

  assign if0.start = start_s[0];  assign if0.abort = abort_s[0];  assign if0.fault_inj = fi_s[0];
  assign if1.start = start_s[1];  assign if1.abort = abort_s[1];  assign if1.fault_inj = fi_s[1];
  assign if2.start = start_s[2];  assign if2.abort = abort_s[2];  assign if2.fault_inj = fi_s[2];

  assign busy_o[0] = if0.busy; assign done_o[0] = if0.done; assign pass_o[0] = if0.pass;
  assign mask_o[0] = if0.fail_mask; assign fvec_o[0] = if0.fail_vec; assign vidx_o[0] = if0.vec_idx;
  assign busy_o[1] = if1.busy; assign done_o[1] = if1.done; assign pass_o[1] = if1.pass;
  assign mask_o[1] = if1.fail_mask; assign fvec_o[1] = if1.fail_vec; assign vidx_o[1] = if1.vec_idx;
  assign busy_o[2] = if2.busy; assign done_o[2] = if2.done; assign pass_o[2] = if2.pass;
  assign mask_o[2] = if2.fail_mask; assign fvec_o[2] = if2.fail_vec; assign vidx_o[2] = if2.vec_idx;

  gate_bank_self_test #(.SETTLE_CYCLES(1), .LOOP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .ctl(if0), .state_o(st_o[0]));
  gate_bank_self_test #(.SETTLE_CYCLES(0), .LOOP(1'b1)) dut1 (
    .clk(clk), .rst(rst), .ctl(if1), .state_o(st_o[1]));
  gate_bank_self_test #(.SETTLE_CYCLES(3), .LOOP(1'b0)) dut2 (
    .clk(clk), .rst(rst), .ctl(if2), .state_o(st_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One single-pass run; f[i] is the fault mask presented during vector i's check.
  task automatic run_pass(input int d, input int s, input logic [6:0] f0, input logic [6:0] f1,
                          input logic [6:0] f2, input logic [6:0] f3, input bit noise,
                          input bit hold_start, input string tag);
    logic [6:0] f [4];
    logic [6:0] em;
    logic [3:0] ev;
    int n;
    int ph;
    int vi;
    bit chk;
    f[0] = f0; f[1] = f1; f[2] = f2; f[3] = f3;
    n  = 4 * (s + 2) + 1;
    em = '0;
    ev = '0;
    for (int i = 0; i < 4; i++) begin
      em    = em | f[i];
      ev[i] = (f[i] != 7'h0);
    end
    start_s[d] = 1'b1;
    fi_s[d]    = noise ? 7'($urandom) : 7'h0;
    tick();
    start_s[d] = hold_start;
    for (int c = 1; c <= n; c++) begin
      ph  = (c - 1) % (s + 2);
      vi  = (c < n) ? (c - 1) / (s + 2) : 3;
      chk = (c < n) && (ph == s + 1);
      if (c == n) start_s[d] = 1'b0;
      fi_s[d] = chk ? f[vi] : (noise ? 7'($urandom) : 7'h0);
      check({tag, ":busy"}, 32'(busy_o[d]), 32'd1);
      check({tag, ":done"}, 32'(done_o[d]), 32'(c == n));
      check({tag, ":vec_idx"}, 32'(vidx_o[d]), 32'(vi));
      if (c == n) begin
        check({tag, ":pass"}, 32'(pass_o[d]), 32'(em == 7'h0));
        check({tag, ":fail_mask"}, 32'(mask_o[d]), 32'(em));
        check({tag, ":fail_vec"}, 32'(fvec_o[d]), 32'(ev));
      end
      tick();
    end
    fi_s[d] = 7'h0;
    check({tag, ":busy_after"}, 32'(busy_o[d]), 32'd0);
    check({tag, ":done_after"}, 32'(done_o[d]), 32'd0);
    check({tag, ":pass_held"}, 32'(pass_o[d]), 32'(em == 7'h0));
  endtask

  initial begin
    logic [6:0] rf [4];
    int d;
    int s;
    int cc;
    int ph;
    int vi;
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      abort_s[i] = 1'b0;
      fi_s[i]    = 7'h0;
    end

    // Reset values on all instances
    #1 rst = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check("rst:busy", 32'(busy_o[i]), 32'd0);
      check("rst:done", 32'(done_o[i]), 32'd0);
      check("rst:pass", 32'(pass_o[i]), 32'd0);
      check("rst:fail_mask", 32'(mask_o[i]), 32'd0);
      check("rst:fail_vec", 32'(fvec_o[i]), 32'd0);
      check("rst:vec_idx", 32'(vidx_o[i]), 32'd0);
      check("rst:state", 32'(st_o[i]), 32'(ST_IDLE));
    end
    rst = 1'b0;
    tick();

    // Clean pass, XOR fault held throughout, fault only on vector 3, clean rerun
    run_pass(0, 1, 7'h00, 7'h00, 7'h00, 7'h00, 1'b0, 1'b0, "clean");
    run_pass(0, 1, 7'h20, 7'h20, 7'h20, 7'h20, 1'b0, 1'b0, "xor_fault");
    run_pass(0, 1, 7'h00, 7'h00, 7'h00, 7'h01, 1'b1, 1'b0, "v3_fault");
    run_pass(0, 1, 7'h00, 7'h00, 7'h00, 7'h00, 1'b1, 1'b1, "rerun");

    // Randomized runs with noise on fault_inj outside check cycles
    for (int r = 0; r < 10; r++) begin
      d = (r % 2 == 0) ? 0 : 2;
      s = (d == 0) ? 1 : 3;
      for (int i = 0; i < 4; i++)
        rf[i] = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(1, 127)) : 7'h0;
      run_pass(d, s, rf[0], rf[1], rf[2], rf[3], 1'b1, 1'($urandom_range(0, 1)), "rand");
      repeat ($urandom_range(0, 3)) tick();
    end

    // Abort during vector 2 wait, after a vector 0 fault was recorded
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      fi_s[0] = (c == 3) ? 7'h11 : 7'h0;
      if (c < 8) tick();
    end
    check("abort:mask_before", 32'(mask_o[0]), 32'h11);
    abort_s[0] = 1'b1;
    tick();
    abort_s[0] = 1'b0;
    check("abort:busy", 32'(busy_o[0]), 32'd0);
    check("abort:fail_mask", 32'(mask_o[0]), 32'd0);
    check("abort:fail_vec", 32'(fvec_o[0]), 32'd0);
    check("abort:vec_idx", 32'(vidx_o[0]), 32'd0);
    check("abort:pass", 32'(pass_o[0]), 32'd0);
    for (int c = 0; c < 15; c++) begin
      check("abort:no_done", 32'(done_o[0]), 32'd0);
      tick();
    end

    // start and abort together in IDLE
    start_s[0] = 1'b1;
    abort_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    abort_s[0] = 1'b0;
    check("start_abort:busy", 32'(busy_o[0]), 32'd0);
    check("start_abort:state", 32'(st_o[0]), 32'(ST_IDLE));
    tick();
    check("start_abort:still_idle", 32'(st_o[0]), 32'(ST_IDLE));

    // Asynchronous reset during the vector 2 check
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      fi_s[0] = (c == 6) ? 7'h40 : 7'h0;
      if (c < 9) tick();
    end
    check("rst_mid:mask_before", 32'(mask_o[0]), 32'h40);
    rst = 1'b1;
    #1;
    check("rst_mid:busy", 32'(busy_o[0]), 32'd0);
    check("rst_mid:done", 32'(done_o[0]), 32'd0);
    check("rst_mid:fail_mask", 32'(mask_o[0]), 32'd0);
    check("rst_mid:fail_vec", 32'(fvec_o[0]), 32'd0);
    check("rst_mid:vec_idx", 32'(vidx_o[0]), 32'd0);
    fi_s[0] = 7'h0;
    tick();
    rst = 1'b0;
    tick();
    run_pass(0, 1, 7'h00, 7'h00, 7'h00, 7'h00, 1'b0, 1'b0, "after_rst");

    // Looping instance, no settle: done every 9 cycles, flags cumulative, abort in DONE
    start_s[1] = 1'b1;
    tick();
    start_s[1] = 1'b0;
    for (int c = 1; c <= 27; c++) begin
      cc = (c - 1) % 9 + 1;
      ph = (cc - 1) % 2;
      vi = (cc < 9) ? (cc - 1) / 2 : 3;
      fi_s[1] = (c == 4) ? 7'h04 : 7'h0;
      check("loop:busy", 32'(busy_o[1]), 32'd1);
      check("loop:done", 32'(done_o[1]), 32'(cc == 9));
      check("loop:vec_idx", 32'(vidx_o[1]), 32'(vi));
      if (cc == 9) begin
        check("loop:pass", 32'(pass_o[1]), 32'd0);
        check("loop:fail_mask", 32'(mask_o[1]), 32'h04);
        check("loop:fail_vec", 32'(fvec_o[1]), 32'h2);
      end
      if (c == 27) abort_s[1] = 1'b1;
      tick();
    end
    abort_s[1] = 1'b0;
    check("loop_abort:busy", 32'(busy_o[1]), 32'd0);
    check("loop_abort:done", 32'(done_o[1]), 32'd0);
    check("loop_abort:state", 32'(st_o[1]), 32'(ST_IDLE));
    check("idle2:state", 32'(st_o[2]), 32'(ST_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
